// File: rtl/uart_cfg_cmd_ctrl.sv
// uart_cfg_cmd_ctrl
// Frames bytes from the UART receiver into 5-byte configuration packets
// (SYNC, ADDR, DHI, DLO, CSUM). It verifies the XOR checksum and issues each
// good packet as a single valid/ready register write.
// Optional build macro: UART_CFG_TIMEOUT_EN. When defined, a partial packet is
// aborted after TIMEOUT_CLKS idle clocks between bytes.
module uart_cfg_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 34720
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  output logic        cfg_valid,
  input  logic        cfg_ready,
  output logic [7:0]  cfg_addr,
  output logic [15:0] cfg_data,
  output logic        pkt_ok,
  output logic        pkt_err,
  output logic [7:0]  err_count,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DHI,
    GET_DLO,
    GET_CSUM,
    ISSUE
  } state_t;

  state_t      state, state_next;
  logic [7:0]  addr_sh, addr_sh_next;
  logic [7:0]  dhi_sh, dhi_sh_next;
  logic [7:0]  dlo_sh, dlo_sh_next;
  logic [7:0]  xor_acc, xor_acc_next;
  logic        cfg_valid_next;
  logic [7:0]  cfg_addr_next;
  logic [15:0] cfg_data_next;
  logic        pkt_ok_next;
  logic        pkt_err_next;
  logic        timeout_hit;

`ifdef UART_CFG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  logic [TW-1:0] tmo_cnt;
  logic          in_get;

  assign in_get = (state == GET_ADDR) || (state == GET_DHI) ||
                  (state == GET_DLO)  || (state == GET_CSUM);

  // An arriving byte always wins over an expiring timeout.
  assign timeout_hit = in_get && !rx_dv && (tmo_cnt == TW'(TIMEOUT_CLKS));

  // Inter-byte idle counter; it only runs while a packet is partly received.
  always_ff @(posedge clk) begin
    if (rst || rx_dv || !in_get || timeout_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  // The timeout length is irrelevant when the abort logic is compiled out.
  logic tmo_len_unused;
  assign tmo_len_unused = (TIMEOUT_CLKS > 0);
  assign timeout_hit    = 1'b0;
`endif

  assign busy = (state != IDLE);

  // Next-state and next-output logic for the packet framer.
  always_comb begin
    state_next     = state;
    addr_sh_next   = addr_sh;
    dhi_sh_next    = dhi_sh;
    dlo_sh_next    = dlo_sh;
    xor_acc_next   = xor_acc;
    cfg_valid_next = cfg_valid;
    cfg_addr_next  = cfg_addr;
    cfg_data_next  = cfg_data;
    pkt_ok_next    = 1'b0;
    pkt_err_next   = 1'b0;

    case (state)
      IDLE: begin
        if (rx_dv && (rx_byte == SYNC_BYTE)) begin
          xor_acc_next = 8'h00;
          state_next   = GET_ADDR;
        end
      end
      GET_ADDR: begin
        if (rx_dv) begin
          addr_sh_next = rx_byte;
          xor_acc_next = xor_acc ^ rx_byte;
          state_next   = GET_DHI;
        end
      end
      GET_DHI: begin
        if (rx_dv) begin
          dhi_sh_next  = rx_byte;
          xor_acc_next = xor_acc ^ rx_byte;
          state_next   = GET_DLO;
        end
      end
      GET_DLO: begin
        if (rx_dv) begin
          dlo_sh_next  = rx_byte;
          xor_acc_next = xor_acc ^ rx_byte;
          state_next   = GET_CSUM;
        end
      end
      GET_CSUM: begin
        if (rx_dv) begin
          if (rx_byte == xor_acc) begin
            cfg_addr_next  = addr_sh;
            cfg_data_next  = {dhi_sh, dlo_sh};
            cfg_valid_next = 1'b1;
            pkt_ok_next    = 1'b1;
            state_next     = ISSUE;
          end else begin
            pkt_err_next = 1'b1;
            state_next   = IDLE;
          end
        end
      end
      ISSUE: begin
        // Bytes arriving while a write is pending are overruns; they are
        // dropped without disturbing the pending write.
        if (rx_dv) begin
          pkt_err_next = 1'b1;
        end
        if (cfg_ready) begin
          cfg_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (timeout_hit) begin
      pkt_err_next = 1'b1;
      state_next   = IDLE;
    end
  end

  // State, shadow registers, bus outputs, status pulses and error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_sh   <= 8'h00;
      dhi_sh    <= 8'h00;
      dlo_sh    <= 8'h00;
      xor_acc   <= 8'h00;
      cfg_valid <= 1'b0;
      cfg_addr  <= 8'h00;
      cfg_data  <= 16'h0000;
      pkt_ok    <= 1'b0;
      pkt_err   <= 1'b0;
      err_count <= 8'h00;
    end else begin
      state     <= state_next;
      addr_sh   <= addr_sh_next;
      dhi_sh    <= dhi_sh_next;
      dlo_sh    <= dlo_sh_next;
      xor_acc   <= xor_acc_next;
      cfg_valid <= cfg_valid_next;
      cfg_addr  <= cfg_addr_next;
      cfg_data  <= cfg_data_next;
      pkt_ok    <= pkt_ok_next;
      pkt_err   <= pkt_err_next;
      if (pkt_err_next && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
